ucbus_master: RTL

- Initiator side of the microcontroller-to-FPGA multiplexed 8-bit bus (ALE / write / read / data) used by the bottom-half responders.
- Accepts single-byte register read/write requests on a valid/ready port and sequences the bus cycles with programmable strobe widths.
- Returns read data on a one-cycle response strobe.
- Used as the host engine in FPGA-hosted test rigs and as the bus driver in responder testbenches.

---
 rtl/ucbus_master.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ucbus_master.sv
// ucbus_master: initiator for the multiplexed 8-bit ALE/write/read/data bus.
// Takes single-byte register read/write requests on a valid/ready port and
// runs the bus cycle with programmable ALE, strobe and hold widths.
// Optional feature macro: UCBUS_MASTER_ADDR_CACHE_EN. When it is defined, the
// address phase is skipped if the same address is already latched in the
// responder.
module ucbus_master #(
  parameter int unsigned ALE_CYC  = 2,
  parameter int unsigned STB_CYC  = 2,
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [7:0] bus_data_o,
  output logic       bus_data_oe,
  input  logic [7:0] bus_data_i,
  output logic       bus_ale,
  output logic       bus_write,
  output logic       bus_read
);

  if (ALE_CYC == 0 || ALE_CYC > 15 || STB_CYC == 0 || STB_CYC > 15 ||
      HOLD_CYC == 0 || HOLD_CYC > 15) begin : g_param_bad
    $error("ucbus_master: ALE_CYC, STB_CYC and HOLD_CYC must be in 1..15");
  end

  // Counter load values: a state lasting N cycles starts at N-1.
  localparam logic [3:0] ALE_LD  = 4'(ALE_CYC - 1);
  localparam logic [3:0] STB_LD  = 4'(STB_CYC - 1);
  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AHOLD,
    S_WSTB,
    S_WHOLD,
    S_TURN,
    S_RSTB,
    S_RHOLD
  } state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       write_q;

  logic       req_ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic [7:0] bus_data_q;
  logic       bus_oe_q;
  logic       bus_ale_q;
  logic       bus_write_q;
  logic       bus_read_q;

  logic       addr_hit;
  logic       ahold_done;

  assign ahold_done = (state_q == S_AHOLD) && (cnt_q == 4'd0);

`ifdef UCBUS_MASTER_ADDR_CACHE_EN
  logic [7:0] cache_addr_q;
  logic       cache_vld_q;

  assign addr_hit = cache_vld_q && (cache_addr_q == req_addr);

  // Remember the address the responder currently holds latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_addr_q <= '0;
      cache_vld_q  <= 1'b0;
    end else if (ahold_done) begin
      cache_addr_q <= addr_q;
      cache_vld_q  <= 1'b1;
    end
  end
`else
  assign addr_hit = 1'b0;
`endif

  // Bus sequencer: state, phase counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      bus_data_q  <= '0;
      bus_oe_q    <= 1'b0;
      bus_ale_q   <= 1'b0;
      bus_write_q <= 1'b1;
      bus_read_q  <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            write_q     <= req_write;
            req_ready_q <= 1'b0;
            if (addr_hit && req_write) begin
              state_q     <= S_WSTB;
              cnt_q       <= STB_LD;
              bus_data_q  <= req_wdata;
              bus_oe_q    <= 1'b1;
              bus_write_q <= 1'b0;
            end else if (addr_hit) begin
              state_q  <= S_TURN;
              cnt_q    <= '0;
              bus_oe_q <= 1'b0;
            end else begin
              state_q    <= S_ADDR;
              cnt_q      <= ALE_LD;
              bus_data_q <= req_addr;
              bus_oe_q   <= 1'b1;
              bus_ale_q  <= 1'b1;
            end
          end
        end

        S_ADDR: begin
          if (cnt_q == 4'd0) begin
            state_q   <= S_AHOLD;
            cnt_q     <= HOLD_LD;
            bus_ale_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_AHOLD: begin
          if (cnt_q == 4'd0) begin
            if (write_q) begin
              state_q     <= S_WSTB;
              cnt_q       <= STB_LD;
              bus_data_q  <= wdata_q;
              bus_write_q <= 1'b0;
            end else begin
              state_q  <= S_TURN;
              cnt_q    <= '0;
              bus_oe_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_WSTB: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_WHOLD;
            cnt_q       <= HOLD_LD;
            bus_write_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_WHOLD: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_IDLE;
            bus_oe_q    <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_TURN: begin
          state_q    <= S_RSTB;
          cnt_q      <= STB_LD;
          bus_read_q <= 1'b0;
        end

        S_RSTB: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_RHOLD;
            cnt_q       <= HOLD_LD;
            bus_read_q  <= 1'b1;
            rsp_rdata_q <= bus_data_i;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_RHOLD: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign bus_data_o  = bus_data_q;
  assign bus_data_oe = bus_oe_q;
  assign bus_ale     = bus_ale_q;
  assign bus_write   = bus_write_q;
  assign bus_read    = bus_read_q;

endmodule
